// File: rtl/mnist_infer_sched_pkg.sv
// Shared definitions for the MNIST inference scheduler: image geometry,
// error digit, scheduler state encoding and image base-address helper.
package mnist_pkg;

    localparam int          IMG_SIZE  = 784;
    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  ERR_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } sched_state_e;

    // Images are packed back to back in BRAM, so the base is a plain product.
    function automatic logic [31:0] img_base(input logic [31:0] idx,
                                             input int unsigned img_size);
        return idx * img_size;
    endfunction

endpackage

// File: rtl/mnist_infer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// request at or above the pointer, wrapping around.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mnist_infer_sched.sv
// Schedules inference jobs onto the shared MNIST accelerator and streams the
// chosen image from BRAM one byte per cycle. Optional watchdog: MNIST_SCHED_TIMEOUT_EN.
module mnist_infer_sched #(
    parameter int  NUM_REQ  = 2,
    parameter int  NUM_IMGS = 3,
    parameter int  IMG_SIZE = mnist_pkg::IMG_SIZE,
    parameter int  IDX_W    = 2,
    parameter int  ADDR_W   = 12,
    parameter int  CNT_W    = 16,
    parameter int  TIMEOUT  = 4096,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_img,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [3:0]               resp_digit,
    output logic [CNT_W-1:0]         resp_cycles,
    output logic                     resp_err,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [7:0]               mem_rd_data,
    output logic                     pix_we,
    output logic [9:0]               pix_addr,
    output logic [7:0]               pix_data,
    output logic                     accel_start,
    input  logic                     accel_done,
    input  logic [3:0]               accel_digit,
    output logic                     busy
);
    import mnist_pkg::*;

    localparam int PIX_W = $clog2(IMG_SIZE + 1);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic               accept;
    logic [ID_W-1:0]    acc_id;
    logic [IDX_W-1:0]   acc_idx;
    logic [CNT_W-1:0]   lat_inc;

`ifndef MNIST_SCHED_TIMEOUT_EN
    localparam int unused_timeout = TIMEOUT;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    assign req_ready = (state_q == S_IDLE) ? arb_grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign lat_inc   = (&lat_q) ? lat_q : lat_q + 1'b1;

    always_comb begin
        acc_id  = '0;
        acc_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                acc_id  = ID_W'(k);
                acc_idx = req_img[k*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        base_d    = base_q;
        pix_cnt_d = pix_cnt_q;
        lat_d     = lat_q;
        digit_d   = digit_q;
        cycles_d  = cycles_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d      = acc_id;
                    ptr_d     = ID_W'((int'(acc_id) + 1) % NUM_REQ);
                    base_d    = ADDR_W'(img_base(32'(acc_idx), IMG_SIZE));
                    pix_cnt_d = '0;
                    // An out-of-range index never touches BRAM or the accelerator.
                    if (int'(acc_idx) >= NUM_IMGS) begin
                        err_d    = 1'b1;
                        digit_d  = ERR_DIGIT;
                        cycles_d = '0;
                        state_d  = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                if (pix_cnt_q == PIX_W'(IMG_SIZE)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_inc;
                if (accel_done) begin
                    digit_d  = accel_digit;
                    cycles_d = lat_inc;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end
`ifdef MNIST_SCHED_TIMEOUT_EN
                else if (lat_inc == CNT_W'(TIMEOUT)) begin
                    digit_d  = ERR_DIGIT;
                    cycles_d = CNT_W'(TIMEOUT);
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            base_q    <= '0;
            pix_cnt_q <= '0;
            lat_q     <= '0;
            digit_q   <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            base_q    <= base_d;
            pix_cnt_q <= pix_cnt_d;
            lat_q     <= lat_d;
            digit_q   <= digit_d;
            cycles_q  <= cycles_d;
            err_q     <= err_d;
        end
    end

    // BRAM has one cycle of read latency, so each write trails its read by one.
    assign mem_rd_en   = (state_q == S_LOAD) && (pix_cnt_q < PIX_W'(IMG_SIZE));
    assign mem_rd_addr = mem_rd_en ? base_q + ADDR_W'(pix_cnt_q) : '0;
    assign pix_we      = (state_q == S_LOAD) && (pix_cnt_q != '0);
    assign pix_addr    = pix_we ? 10'(pix_cnt_q - 1'b1) : '0;
    assign pix_data    = pix_we ? mem_rd_data : '0;
    assign accel_start = (state_q == S_START);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = id_q;
    assign resp_digit  = digit_q;
    assign resp_cycles = cycles_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
